// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package div_pkg;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIN
    } div_state_t;

    // Quotient reported for an unsigned (or non-negative signed) divide-by-zero;
    // sliced down to the operand width by the user.
    localparam logic [31:0] DIV0_Q_ALL = '1;

    // Bits needed to hold values 0..n-1, never less than one
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (((n - 1) >> i) != 0) begin
                w = i + 1;
            end
        end
        if (w == 0) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/div_seq_nb_if.sv
// Start/busy/done handshake and operand/result bus for div_seq_nb.
interface div_seq_nb_if #(
    parameter int unsigned N = 8
);
    logic         START;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         BUSY;
    logic         DONE;
    logic [N-1:0] Q;
    logic [N-1:0] R;
    logic         DIV0;

    // Requester side
    modport master (
        output START, A, B,
        input  BUSY, DONE, Q, R, DIV0
    );

    // Divider side
    modport slave (
        input  START, A, B,
        output BUSY, DONE, Q, R, DIV0
    );
endinterface

// File: rtl/div_ctrl_fsm.sv
// Sequencing for div_seq_nb: state, iteration counter, BUSY/DONE and the
// datapath enables (operand load, zero-divisor load, shift, final load).
module div_ctrl_fsm
    import div_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic i_start,
    input  logic i_b_zero,
    output logic o_busy,
    output logic o_done,
    output logic o_load,
    output logic o_zload,
    output logic o_shift,
    output logic o_fin
);
    localparam int unsigned CW = clog2(N);

    div_state_t      r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_busy;
    logic            r_done;
    logic            w_accept;

    // State register, iteration counter and registered BUSY/DONE
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        if (i_b_zero) begin
                            r_state <= ST_FIN;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_RUN;
                            r_busy  <= 1'b1;
                            r_cnt   <= CW'(N - 1);
                        end
                    end
                end
                ST_RUN: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_FIN;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_FIN: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Datapath enables decoded from the current state
    always_comb begin
        w_accept = (r_state == ST_IDLE) && i_start;
        o_load   = w_accept && !i_b_zero;
        o_zload  = w_accept && i_b_zero;
        o_shift  = (r_state == ST_RUN);
        o_fin    = (r_state == ST_RUN) && (r_cnt == '0);
    end

    assign o_busy = r_busy;
    assign o_done = r_done;

endmodule

// File: rtl/div_seq_nb.sv
// Multi-cycle restoring divider, one quotient bit per clock.
// Optional feature macro: DIV_SIGNED_EN (two's-complement operands/results).
module div_seq_nb
    import div_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    div_seq_nb_if.slave      bus
);
    logic [N-1:0] w_a;
    logic [N-1:0] w_b;
    logic [N-1:0] w_a_mag;
    logic [N-1:0] w_b_mag;
    logic [N-1:0] w_q_div0;
    logic [N:0]   w_rem_sh;
    logic [N+1:0] w_trial;
    logic         w_ge;
    logic [N:0]   w_rem_nx;
    logic [N-1:0] w_quo_nx;
    logic [N-1:0] w_q_fin;
    logic [N-1:0] w_r_fin;

    logic         w_busy;
    logic         w_done;
    logic         w_load;
    logic         w_zload;
    logic         w_shift;
    logic         w_fin;

    logic [N:0]   r_rem;
    logic [N-1:0] r_quo;
    logic [N-1:0] r_b;
    logic [N-1:0] r_q;
    logic [N-1:0] r_r;
    logic         r_div0;
`ifdef DIV_SIGNED_EN
    logic         r_neg_q;
    logic         r_neg_r;
`endif

    div_ctrl_fsm #(
        .N (N)
    ) u_ctrl (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .i_start  (bus.START),
        .i_b_zero (w_b == '0),
        .o_busy   (w_busy),
        .o_done   (w_done),
        .o_load   (w_load),
        .o_zload  (w_zload),
        .o_shift  (w_shift),
        .o_fin    (w_fin)
    );

    assign w_a = bus.A;
    assign w_b = bus.B;

    // Operand magnitudes and divide-by-zero quotient
    always_comb begin
`ifdef DIV_SIGNED_EN
        w_a_mag  = w_a[N-1] ? ('0 - w_a) : w_a;
        w_b_mag  = w_b[N-1] ? ('0 - w_b) : w_b;
        w_q_div0 = w_a[N-1] ? N'(1) : DIV0_Q_ALL[N-1:0];
`else
        w_a_mag  = w_a;
        w_b_mag  = w_b;
        w_q_div0 = DIV0_Q_ALL[N-1:0];
`endif
    end

    // One restoring step: shift {rem,quo}, trial subtract, keep or restore.
    // The final step feeds the output registers directly so results land on
    // the same edge that leaves RUN.
    always_comb begin
        w_rem_sh = {r_rem[N-1:0], r_quo[N-1]};
        w_trial  = {1'b0, w_rem_sh} - {2'b00, r_b};
        w_ge     = ~w_trial[N+1];
        w_rem_nx = w_ge ? w_trial[N:0] : w_rem_sh;
        w_quo_nx = {r_quo[N-2:0], w_ge};
`ifdef DIV_SIGNED_EN
        w_q_fin  = r_neg_q ? ('0 - w_quo_nx) : w_quo_nx;
        w_r_fin  = r_neg_r ? ('0 - w_rem_nx[N-1:0]) : w_rem_nx[N-1:0];
`else
        w_q_fin  = w_quo_nx;
        w_r_fin  = w_rem_nx[N-1:0];
`endif
    end

    // Working registers and held result registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_rem   <= '0;
            r_quo   <= '0;
            r_b     <= '0;
            r_q     <= '0;
            r_r     <= '0;
            r_div0  <= 1'b0;
`ifdef DIV_SIGNED_EN
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
`endif
        end else begin
            if (w_load) begin
                r_rem   <= '0;
                r_quo   <= w_a_mag;
                r_b     <= w_b_mag;
`ifdef DIV_SIGNED_EN
                r_neg_q <= w_a[N-1] ^ w_b[N-1];
                r_neg_r <= w_a[N-1];
`endif
            end
            if (w_shift) begin
                r_rem <= w_rem_nx;
                r_quo <= w_quo_nx;
            end
            if (w_fin) begin
                r_q    <= w_q_fin;
                r_r    <= w_r_fin;
                r_div0 <= 1'b0;
            end
            if (w_zload) begin
                r_q    <= w_q_div0;
                r_r    <= w_a;
                r_div0 <= 1'b1;
            end
        end
    end

    assign bus.BUSY = w_busy;
    assign bus.DONE = w_done;
    assign bus.Q    = r_q;
    assign bus.R    = r_r;
    assign bus.DIV0 = r_div0;

endmodule

// File: tb/tb_div_seq_nb.sv
// Directed bench for div_seq_nb (N=8), default unsigned build; signed vectors
// are added when DIV_SIGNED_EN is defined.
module tb_div_seq_nb;
    localparam int unsigned N = 8;

    logic CLK = 1'b0;
    logic RST_N;
    int   n_checks = 0;
    int   n_errors = 0;

    div_seq_nb_if #(.N(N)) bus ();

    div_seq_nb #(
        .N (N)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Caller is between edges; accept happens on the next posedge.
    // a2/b2 are driven after the accept; hold keeps START high through RUN.
    task automatic run_div(input string tag,
                           input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] a2, input logic [7:0] b2,
                           input bit hold,
                           input logic [7:0] eq, input logic [7:0] er,
                           input bit ediv0);
        int busy_n;
        int done_k;
        int exp_k;
        busy_n = 0;
        done_k = -1;
        exp_k  = ediv0 ? 0 : N;
        bus.A = a;
        bus.B = b;
        bus.START = 1'b1;
        @(posedge CLK);
        #1;
        if (!hold) bus.START = 1'b0;
        bus.A = a2;
        bus.B = b2;
        for (int k = 0; k < 40 && done_k < 0; k++) begin
            if (k > 0) begin
                @(posedge CLK);
                #1;
            end
            if (bus.BUSY) busy_n++;
            if (bus.DONE) done_k = k;
        end
        bus.START = 1'b0;
        if (done_k < 0) begin
            check({tag, "/timeout"}, 32'd0, 32'd1);
        end else begin
            check({tag, "/latency"}, done_k, exp_k);
            check({tag, "/busy_cycles"}, busy_n, ediv0 ? 0 : N);
            check({tag, "/q"}, bus.Q, eq);
            check({tag, "/r"}, bus.R, er);
            check({tag, "/div0"}, bus.DIV0, ediv0);
            @(posedge CLK);
            #1;
            check({tag, "/done_pulse"}, bus.DONE, 1'b0);
            check({tag, "/q_held"}, bus.Q, eq);
        end
    endtask

    initial begin
        int done_seen;
        RST_N     = 1'b0;
        bus.START = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        #12;
        check("rst/busy", bus.BUSY, 1'b0);
        check("rst/done", bus.DONE, 1'b0);
        check("rst/q", bus.Q, 8'h00);
        check("rst/r", bus.R, 8'h00);
        check("rst/div0", bus.DIV0, 1'b0);
        #10;
        RST_N = 1'b1;

        // First edge after reset release accepts
        run_div("100/7", 8'd100, 8'd7, 8'd0, 8'd0, 1'b0, 8'd14, 8'd2, 1'b0);
        // Back-to-back at earliest accept
        run_div("255/1", 8'd255, 8'd1, 8'd0, 8'd0, 1'b0, 8'd255, 8'd0, 1'b0);
        run_div("3/200", 8'd3, 8'd200, 8'd0, 8'd0, 1'b0, 8'd0, 8'd3, 1'b0);
        // Divide by zero, then earliest next accept clears DIV0
        run_div("37/0", 8'd37, 8'd0, 8'd0, 8'd0, 1'b0, 8'hFF, 8'd37, 1'b1);
        run_div("7/7", 8'd7, 8'd7, 8'd0, 8'd0, 1'b0, 8'd1, 8'd0, 1'b0);
        // START held with new operands during RUN is ignored
`ifdef DIV_SIGNED_EN
        run_div("hold", 8'd200, 8'd9, 8'd10, 8'd3, 1'b1, 8'hFA, 8'hFE, 1'b0);
`else
        run_div("hold", 8'd200, 8'd9, 8'd10, 8'd3, 1'b1, 8'd22, 8'd2, 1'b0);
`endif
        run_div("0/5", 8'd0, 8'd5, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0, 1'b0);

        // Reset during the 4th RUN cycle
        bus.A = 8'd100;
        bus.B = 8'd7;
        bus.START = 1'b1;
        @(posedge CLK);
        #1;
        bus.START = 1'b0;
        repeat (3) begin
            @(posedge CLK);
            #1;
        end
        check("midrst/busy_before", bus.BUSY, 1'b1);
        #2;
        RST_N = 1'b0;
        #1;
        check("midrst/busy", bus.BUSY, 1'b0);
        check("midrst/done", bus.DONE, 1'b0);
        check("midrst/q", bus.Q, 8'h00);
        check("midrst/r", bus.R, 8'h00);
        check("midrst/div0", bus.DIV0, 1'b0);
        @(negedge CLK);
        RST_N = 1'b1;
        done_seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge CLK);
            #1;
            if (bus.DONE) done_seen++;
        end
        check("midrst/no_done", done_seen, 0);
        run_div("50/5", 8'd50, 8'd5, 8'd0, 8'd0, 1'b0, 8'd10, 8'd0, 1'b0);

`ifdef DIV_SIGNED_EN
        run_div("s-100/7", 8'h9C, 8'd7, 8'd0, 8'd0, 1'b0, 8'hF2, 8'hFE, 1'b0);
        run_div("s-128/-1", 8'h80, 8'hFF, 8'd0, 8'd0, 1'b0, 8'h80, 8'h00, 1'b0);
        run_div("s-5/0", 8'hFB, 8'd0, 8'd0, 8'd0, 1'b0, 8'h01, 8'hFB, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
